// File: rtl/spi_defs.sv
// Shared SPI definitions: FSM state encodings and default timing constants
// used by the frame shifter, the SCLK generator and the ADC controller.
package spi_defs;

    localparam int DEF_FRAME_BITS      = 32;
    localparam int DEF_CS_SETUP_CYCLES = 4;
    localparam int DEF_CS_HOLD_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_frame_shifter_if.sv
// Bus between a frame requester / SCLK generator / ADC and the frame shifter.
// start is a level request honoured only while idle; rx_valid and timeout are
// single-cycle pulses with no backpressure; dbg_state mirrors the FSM.
interface spi_frame_shifter_if
    import spi_defs::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS
);
    logic                  start;
    logic [FRAME_BITS-1:0] tx_word;
    logic                  busy;
    logic                  sclk_enable;
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [FRAME_BITS-1:0] rx_word;
    logic                  rx_valid;
    logic                  timeout;
    logic [2:0]            dbg_state;

    modport slave (
        input  start, tx_word, spi_sclk, spi_miso,
        output busy, sclk_enable, spi_cs_n, spi_mosi, rx_word, rx_valid, timeout, dbg_state
    );

    modport master (
        output start, tx_word, spi_sclk, spi_miso,
        input  busy, sclk_enable, spi_cs_n, spi_mosi, rx_word, rx_valid, timeout, dbg_state
    );
endinterface

// File: rtl/sclk_edge_detect.sv
// Detects SCLK edges by comparing spi_sclk with its value one input_clock earlier.
module sclk_edge_detect (
    input  logic input_clock,
    input  logic reset_n,
    input  logic spi_sclk,
    output logic rise,
    output logic fall
);
    logic r_sclk_d;

    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) r_sclk_d <= 1'b0;
        else          r_sclk_d <= spi_sclk;
    end

    assign rise = spi_sclk & ~r_sclk_d;
    assign fall = ~spi_sclk & r_sclk_d;
endmodule

// File: rtl/spi_frame_shifter.sv
// SPI mode-1 frame shifter: CS setup, MSB-first shift on an external SCLK,
// CS hold, then a one-cycle rx_valid; aborts if SCLK stalls too long.
module spi_frame_shifter
    import spi_defs::*;
#(
    parameter int FRAME_BITS      = DEF_FRAME_BITS,
    parameter int CS_SETUP_CYCLES = DEF_CS_SETUP_CYCLES,
    parameter int CS_HOLD_CYCLES  = DEF_CS_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input logic                 input_clock,
    input logic                 reset_n,
    spi_frame_shifter_if.slave  bus
);
    localparam int FCNT_W = $clog2(FRAME_BITS + 1);
    localparam int PH_W   = $clog2(max2(CS_SETUP_CYCLES, CS_HOLD_CYCLES) + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(FRAME_BITS - 1);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            r_state;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_word;
    logic                  r_mosi;
    logic                  r_timeout;
    logic                  r_tail;
    logic [FCNT_W-1:0]     r_fcnt;
    logic [PH_W-1:0]       r_ph_cnt;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  w_rise;
    logic                  w_fall;

    sclk_edge_detect u_edge (
        .input_clock (input_clock),
        .reset_n     (reset_n),
        .spi_sclk    (bus.spi_sclk),
        .rise        (w_rise),
        .fall        (w_fall)
    );

    always_ff @(posedge input_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_word  <= '0;
            r_mosi     <= 1'b0;
            r_timeout  <= 1'b0;
            r_tail     <= 1'b0;
            r_fcnt     <= '0;
            r_ph_cnt   <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_tx_shift <= bus.tx_word;
                        r_rx_shift <= '0;
                        r_mosi     <= 1'b0;
                        r_tail     <= 1'b0;
                        r_fcnt     <= '0;
                        r_ph_cnt   <= '0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (r_ph_cnt == SETUP_LAST) begin
                        r_ph_cnt <= '0;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                ST_SHIFT: begin
                    // r_tail is the single cycle with SCLK disabled before CS hold starts
                    if (r_tail) begin
                        r_tail  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_state <= ST_CS_HOLD;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_mosi    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                        if (w_fall) begin
                            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], bus.spi_miso};
                            r_fcnt     <= r_fcnt + FCNT_W'(1);
                            if (r_fcnt == FCNT_LAST) r_tail <= 1'b1;
                        end else if (w_rise) begin
                            r_mosi     <= r_tx_shift[FRAME_BITS-1];
                            r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (r_ph_cnt == HOLD_LAST) begin
                        r_rx_word <= r_rx_shift;
                        r_state   <= ST_DONE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.sclk_enable = (r_state == ST_SHIFT) && !r_tail;
    assign bus.spi_cs_n    = !((r_state == ST_CS_SETUP) || (r_state == ST_SHIFT) ||
                               (r_state == ST_CS_HOLD));
    assign bus.spi_mosi    = r_mosi;
    assign bus.rx_word     = r_rx_word;
    assign bus.rx_valid    = (r_state == ST_DONE);
    assign bus.timeout     = r_timeout;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_spi_frame_shifter.sv
// Bench for spi_frame_shifter: SCLK generator and mode-1 ADC model, a monitor
// that reconstructs frames from the pins, and one task per scenario.
module tb_spi_frame_shifter;
  import spi_defs::*;

  localparam int FB     = 32;
  localparam int TO_CYC = 100;
  localparam int SETUP  = 4;
  localparam int HOLD   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  spi_frame_shifter_if #(.FRAME_BITS(FB)) bus ();
  spi_frame_shifter_if #(.FRAME_BITS(FB)) bus_to ();

  spi_frame_shifter #(.FRAME_BITS(FB)) dut (
    .input_clock (clk),
    .reset_n     (rst_n),
    .bus         (bus)
  );

  spi_frame_shifter #(.FRAME_BITS(FB), .TIMEOUT_CYCLES(TO_CYC)) dut_to (
    .input_clock (clk),
    .reset_n     (rst_n),
    .bus         (bus_to)
  );

  assign bus_to.spi_sclk = 1'b0;
  assign bus_to.spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  // SCLK generator (half period = half cycles) and ADC driving MISO on rising SCLK
  int            half = 6;
  int            gen_cnt = 0;
  logic [FB-1:0] miso_word = '0;
  int            miso_idx = 0;

  always @(negedge clk) begin
    if (bus.sclk_enable !== 1'b1) begin
      bus.spi_sclk = 1'b0;
      gen_cnt = 0;
      if (miso_idx == 0) bus.spi_miso = 1'b0;
    end else begin
      gen_cnt++;
      if (gen_cnt >= half) begin
        gen_cnt = 0;
        bus.spi_sclk = ~bus.spi_sclk;
        if (bus.spi_sclk) begin
          bus.spi_miso = (miso_idx < FB) ? miso_word[FB-1-miso_idx] : 1'b0;
          miso_idx++;
        end
      end
    end
  end

  // Pin monitor
  int            cyc = 0;
  logic          sclk_q = 1'b0;
  logic          cs_q = 1'b1;
  int            fall_cnt, rise_cnt, rxv_cnt, hold_mosi_bad;
  int            first_rise_cyc, last_fall_cyc, cs_fall_cyc, cs_rise_cyc;
  logic [FB-1:0] rx_seen;
  logic          mosi_q[$];

  task automatic clear_mon();
    fall_cnt = 0; rise_cnt = 0; rxv_cnt = 0; hold_mosi_bad = 0;
    first_rise_cyc = -1; last_fall_cyc = -1; cs_fall_cyc = -1; cs_rise_cyc = -1;
    rx_seen = '0;
    mosi_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.spi_sclk === 1'b1 && sclk_q === 1'b0) begin
      rise_cnt++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
    end
    if (bus.spi_sclk === 1'b0 && sclk_q === 1'b1) begin
      fall_cnt++;
      last_fall_cyc = cyc;
      mosi_q.push_back(bus.spi_mosi);
    end
    if (bus.spi_cs_n === 1'b0 && cs_q === 1'b1) cs_fall_cyc = cyc;
    if (bus.spi_cs_n === 1'b1 && cs_q === 1'b0) cs_rise_cyc = cyc;
    if (fall_cnt == FB && cyc > last_fall_cyc && bus.spi_cs_n === 1'b0 && bus.spi_mosi !== 1'b0)
      hold_mosi_bad++;
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_seen = bus.rx_word;
    end
    sclk_q = bus.spi_sclk;
    cs_q   = bus.spi_cs_n;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [FB-1:0] tx, input logic [FB-1:0] mw, input int h);
    half = h;
    miso_word = mw;
    miso_idx = 0;
    clear_mon();
    bus.tx_word = tx;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.tx_word = $urandom;
  endtask

  // Waits for the frame's rx_valid, then checks data, bit order and pulse count
  task automatic finish_frame(input logic [FB-1:0] tx, input logic [FB-1:0] mw, input string tag);
    logic [FB-1:0] got;
    for (int i = 0; i < 4000 && rxv_cnt == 0; i++) tick();
    checks++;
    if (rxv_cnt == 0) begin
      errors++;
      $display("FAIL %s rx_valid_wait: got 0 pulses, required 1 within 4000 cycles", tag);
      return;
    end
    repeat (4) tick();
    checks++;
    if (rx_seen !== mw) begin
      errors++;
      $display("FAIL %s rx_word: got %h, required %h", tag, rx_seen, mw);
    end
    checks++;
    if (rxv_cnt !== 1) begin
      errors++;
      $display("FAIL %s rx_valid_count: got %0d, required 1", tag, rxv_cnt);
    end
    got = '0;
    foreach (mosi_q[i]) got = {got[FB-2:0], mosi_q[i]};
    checks++;
    if (mosi_q.size() != FB || got !== tx) begin
      errors++;
      $display("FAIL %s mosi_bits: got %h (%0d bits), required %h (%0d bits)",
               tag, got, mosi_q.size(), tx, FB);
    end
    checks++;
    if (hold_mosi_bad != 0) begin
      errors++;
      $display("FAIL %s hold_mosi: got %0d nonzero cycles, required 0", tag, hold_mosi_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.tx_word = '0;
    bus_to.start = 1'b0;
    bus_to.tx_word = '0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.sclk_enable, bus.spi_cs_n, bus.spi_mosi, bus.rx_valid, bus.timeout} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_outputs: got busy/en/cs_n/mosi/rxv/to=%b, required 001000",
               {bus.busy, bus.sclk_enable, bus.spi_cs_n, bus.spi_mosi, bus.rx_valid, bus.timeout});
    end
    checks++;
    if (bus.rx_word !== '0) begin
      errors++;
      $display("FAIL reset_rx_word: got %h, required 0", bus.rx_word);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_frame(32'hA5A5_0F0F, 32'h1234_5678, 6);
    finish_frame(32'hA5A5_0F0F, 32'h1234_5678, "basic");
  endtask

  task automatic test_cs_timing();
    logic [FB-1:0] tx, mw;
    tx = $urandom; mw = $urandom;
    start_frame(tx, mw, 6);
    finish_frame(tx, mw, "timing");
    checks++;
    if (cs_fall_cyc < 0 || first_rise_cyc - cs_fall_cyc < SETUP) begin
      errors++;
      $display("FAIL cs_setup: got %0d cycles, required >= %0d", first_rise_cyc - cs_fall_cyc, SETUP);
    end
    checks++;
    if (cs_rise_cyc - last_fall_cyc != HOLD + 1) begin
      errors++;
      $display("FAIL cs_hold: got %0d cycles, required %0d", cs_rise_cyc - last_fall_cyc, HOLD + 1);
    end
  endtask

  task automatic test_random_frames();
    logic [FB-1:0] tx, mw;
    for (int n = 0; n < 3; n++) begin
      tx = $urandom; mw = $urandom;
      start_frame(tx, mw, $urandom_range(2, 6));
      finish_frame(tx, mw, $sformatf("random%0d", n));
    end
  endtask

  task automatic test_start_held();
    logic [FB-1:0] tx, mw;
    int busy_low;
    tx = $urandom; mw = $urandom;
    half = 6; miso_word = mw; miso_idx = 0;
    clear_mon();
    bus.tx_word = tx;
    bus.start = 1'b1;
    tick();
    bus.tx_word = $urandom;
    busy_low = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy !== 1'b1) busy_low++;
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL held_busy: got %0d low cycles, required 0", busy_low);
    end
    finish_frame(tx, mw, "held");
    repeat (20) tick();
    checks++;
    if (rxv_cnt != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_single_frame: got %0d frames busy=%b, required 1 frame busy=0",
               rxv_cnt, bus.busy);
    end
  endtask

  task automatic test_timeout();
    int k, en_cyc, to_cyc, to_pulses, rxv;
    logic cs_at_to, en_at_to;
    en_cyc = -1; to_cyc = -1; to_pulses = 0; rxv = 0;
    cs_at_to = 1'b0; en_at_to = 1'b1;
    bus_to.tx_word = $urandom;
    bus_to.start = 1'b1;
    tick();
    bus_to.start = 1'b0;
    for (k = 1; k < 300; k++) begin
      if (en_cyc < 0 && bus_to.sclk_enable === 1'b1) en_cyc = k;
      if (bus_to.timeout === 1'b1) begin
        to_pulses++;
        if (to_cyc < 0) begin
          to_cyc = k; cs_at_to = bus_to.spi_cs_n; en_at_to = bus_to.sclk_enable;
        end
      end
      if (bus_to.rx_valid === 1'b1) rxv++;
      tick();
    end
    checks++;
    if (to_cyc < 0 || en_cyc < 0 || to_cyc - en_cyc != TO_CYC) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles, required %0d", to_cyc - en_cyc, TO_CYC);
    end
    checks++;
    if (cs_at_to !== 1'b1 || en_at_to !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pins: got cs_n=%b en=%b, required cs_n=1 en=0", cs_at_to, en_at_to);
    end
    checks++;
    if (to_pulses != 1 || rxv != 0 || bus_to.rx_word !== '0) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses %0d rx_valid rx_word=%h, required 1/0/0",
               to_pulses, rxv, bus_to.rx_word);
    end
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] tx, mw;
    start_frame($urandom, $urandom, 3);
    for (int i = 0; i < 2000 && fall_cnt < 10; i++) tick();
    checks++;
    if (fall_cnt < 10) begin
      errors++;
      $display("FAIL midreset_wait: got %0d falls, required 10", fall_cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.spi_cs_n !== 1'b1 || bus.sclk_enable !== 1'b0 || bus.busy !== 1'b0 || bus.rx_word !== '0) begin
      errors++;
      $display("FAIL midreset_pins: got cs_n=%b en=%b busy=%b rx_word=%h, required 1/0/0/0",
               bus.spi_cs_n, bus.sclk_enable, bus.busy, bus.rx_word);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    tx = $urandom; mw = $urandom;
    start_frame(tx, mw, 4);
    finish_frame(tx, mw, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] tx1, mw1, tx2, mw2;
    logic busy_done_next, busy_accept;
    tx1 = $urandom; mw1 = $urandom; tx2 = $urandom; mw2 = $urandom;
    start_frame(tx1, mw1, 2);
    for (int i = 0; i < 4000 && bus.rx_valid !== 1'b1; i++) tick();
    checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_word !== mw1) begin
      errors++;
      $display("FAIL b2b_first: got rx_valid=%b rx_word=%h, required 1 and %h",
               bus.rx_valid, bus.rx_word, mw1);
    end
    bus.start = 1'b1;
    bus.tx_word = ~tx2;
    miso_word = mw2;
    miso_idx = 0;
    tick();
    clear_mon();
    busy_done_next = bus.busy;
    bus.tx_word = tx2;
    tick();
    busy_accept = bus.busy;
    bus.start = 1'b0;
    bus.tx_word = $urandom;
    checks++;
    if (busy_done_next !== 1'b0 || busy_accept !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy %b then %b, required 0 then 1", busy_done_next, busy_accept);
    end
    finish_frame(tx2, mw2, "b2b_second");
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_cs_timing();
    test_random_frames();
    test_start_held();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at 3 ms, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
